mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Execute-stage multiply/divide unit of the pipelined MIPS core; owns HI/LO.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and holds busy for a fixed latency.
//  The hazard unit stalls D on busy|start when an MD-class instruction is in D.
//  HI/LO outputs feed the E-stage forwarding mux for MFHI/MFLO.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      op valid this cycle (E-stage instr is MD-class, not bubble)
//  op      in   3      md_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  a       in   WIDTH  rs operand (forwarded)
//  b       in   WIDTH  rt operand (forwarded)
//  busy    out  1      operation in flight
//  hi      out  WIDTH  architectural HI
//  lo      out  WIDTH  architectural LO
//  flush   in   1      only with MDU_FLUSH_EN: cancel in-flight op
// BEHAVIOUR
//  Reset (reset==0, async): busy=0, hi=0, lo=0, counter=0, state=IDLE.
//  FSM IDLE/RUN. IDLE & start & op in {MULT,MULTU,DIV,DIVU}: latch a, b, op at edge;
//  ->RUN, busy=1 from next cycle, cnt=MULT_CYCLES-1 or DIV_CYCLES-1.
//  RUN: cnt decrements each edge; at edge with cnt==0 commit hi/lo, busy=0, ->IDLE.
//  Net: start in cycle T -> busy high T+1..T+N -> new hi/lo visible at T+N+1.
//  start while busy: ignored entirely (upstream guarantees no issue; assert in sim).
//  MTHI/MTLO with start in IDLE: write a to hi/lo at that edge, busy stays 0.
//  MULT: {hi,lo} = signed a * signed b (2*WIDTH). MULTU: unsigned product.
//  DIV: lo = a/b truncated toward zero, hi = remainder with sign of a.
//   INT_MIN/-1: lo=0x8000_0000, hi=0. DIVU: unsigned quotient/remainder.
//  Divide by zero (b==0): op runs full DIV_CYCLES, hi/lo unchanged at commit.
//  Results computed from latched operands; a/b changing during RUN have no effect.
//  op==NONE with start: no-op. reset asserted mid-RUN: immediate return to reset state.
//  hi/lo change only at commit or MTHI/MTLO edge; readers see the old value while busy.
// CONFIGURATION
//  MDU_FLUSH_EN defined: flush port exists. flush=1 in RUN: ->IDLE at next edge,
//   busy=0, hi/lo unchanged. flush && start same cycle in IDLE: start ignored.
//   flush in the commit cycle wins (no commit).
//  MDU_FLUSH_EN undefined: no flush port; in-flight ops always commit.
// STRUCTURE
//  Package mdu_pkg: md_op_t encoding, state enum (IDLE, RUN), default latency constants.
//  Sub-module mdu_arith (combinational): latched op/a/b -> next_hi, next_lo, div_zero.
//  Top holds FSM, counter, operand latches and HI/LO registers.
// TESTING
//  MULT a=0xFFFF_FFFE b=3, start 1 cycle -> busy 5 cycles; then hi=0xFFFF_FFFF lo=0xFFFF_FFFA.
//  MULTU a=0xFFFF_FFFF b=2 -> hi=0x0000_0001 lo=0xFFFF_FFFE, busy exactly 5 cycles.
//  DIV a=-7 b=2 -> lo=0xFFFF_FFFD hi=0xFFFF_FFFF after 10 busy cycles;
//   DIV 0x8000_0000/-1 -> lo=0x8000_0000 hi=0.
//  MTHI a=0x1234 then DIVU b=0 -> hi=0x1234 after the write edge;
//   after 10 busy cycles hi/lo unchanged.
//  start MULT during busy, and a/b toggled mid-op -> ignored; result matches first op.
//  Async reset mid-RUN -> busy=0 hi=lo=0 without a clock edge.
//  With MDU_FLUSH_EN: flush on 3rd busy cycle -> busy=0 next cycle, hi/lo keep old values.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and default latencies for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    localparam int MDU_WIDTH       = 32;
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage <-> MDU bundle. The flush signal exists only when MDU_FLUSH_EN is defined.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    import mdu_pkg::*;

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_FLUSH_EN
    logic             flush;
`endif

    modport master (
`ifdef MDU_FLUSH_EN
        output flush,
`endif
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
`ifdef MDU_FLUSH_EN
        input  flush,
`endif
        input  start, op, a, b,
        output busy, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: latched op/operands -> candidate HI/LO and divide-by-zero flag.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo,
    output logic             div_zero
);

    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    logic                      sovf;
    logic        [WIDTH-1:0]   sdiv_b;
    logic        [WIDTH-1:0]   udiv_b;
    logic signed [WIDTH-1:0]   sq;
    logic signed [WIDTH-1:0]   sr;
    logic        [WIDTH-1:0]   uq;
    logic        [WIDTH-1:0]   ur;

    assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // INT_MIN / -1 divides by 1 instead: yields quotient INT_MIN, remainder 0
    assign sovf   = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign sdiv_b = ((b == '0) || sovf) ? WIDTH'(1) : b;
    assign udiv_b = (b == '0) ? WIDTH'(1) : b;

    assign sq = $signed(a) / $signed(sdiv_b);
    assign sr = $signed(a) % $signed(sdiv_b);
    assign uq = a / udiv_b;
    assign ur = a % udiv_b;

    always_comb begin
        next_hi  = '0;
        next_lo  = '0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  {next_hi, next_lo} = $unsigned(sprod);
            MD_MULTU: {next_hi, next_lo} = uprod;
            MD_DIV: begin
                next_lo  = $unsigned(sq);
                next_hi  = $unsigned(sr);
                div_zero = (b == '0);
            end
            MD_DIVU: begin
                next_lo  = uq;
                next_hi  = ur;
                div_zero = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning HI/LO: fixed-latency IDLE/RUN FSM around mdu_arith.
// Optional in-flight cancel via `define MDU_FLUSH_EN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = MDU_WIDTH,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   io
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_t           op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             latch_en;
    logic             flush_w;
    logic [WIDTH-1:0] next_hi, next_lo;
    logic             div_zero;

`ifdef MDU_FLUSH_EN
    assign flush_w = io.flush;
`else
    assign flush_w = 1'b0;
`endif

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .next_hi  (next_hi),
        .next_lo  (next_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (latch_en) begin
                op_q <= io.op;
                a_q  <= io.a;
                b_q  <= io.b;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in the same cycle suppresses any issue, including MTHI/MTLO
                if (io.start && !flush_w) begin
                    case (io.op)
                        MD_MULT, MD_MULTU: begin
                            latch_en = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES - 1);
                            state_d  = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            latch_en = 1'b1;
                            cnt_d    = CW'(DIV_CYCLES - 1);
                            state_d  = RUN;
                        end
                        MD_MTHI: hi_d = io.a;
                        MD_MTLO: lo_d = io.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (!div_zero) begin
                        hi_d = next_hi;
                        lo_d = next_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.busy = (state_q == RUN);
    assign io.hi   = hi_q;
    assign io.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
// Define MDU_FLUSH_EN to also exercise the flush path.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int NMULT = 5;
    localparam int NDIV  = 10;

    logic clk;
    logic rst_n;

    mult_div_unit_if #(.WIDTH(32)) io ();

    mult_div_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (NMULT),
        .DIV_CYCLES  (NDIV)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural HI/LO effect of one issued op, from plain 64-bit arithmetic
    task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            MD_MULTU: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            MD_DIV: if (b != 0) begin
                p = sa / sb; exp_lo = p[31:0];
                p = sa % sb; exp_hi = p[31:0];
            end
            MD_DIVU: if (b != 0) begin
                p = ua / ub; exp_lo = p[31:0];
                p = ua % ub; exp_hi = p[31:0];
            end
            MD_MTHI:  exp_hi = a;
            MD_MTLO:  exp_lo = a;
            default: ;
        endcase
    endtask

    function automatic int latency(input md_op_t op);
        case (op)
            MD_MULT, MD_MULTU: return NMULT;
            MD_DIV, MD_DIVU:   return NDIV;
            default:           return 0;
        endcase
    endfunction

    // Issue one op for a single cycle, then follow it to completion.
    // disturb: scramble a/b and fire an extra MULT while busy; both must be ignored.
    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb);
        int n;
        @(negedge clk);
        io.start = 1'b1; io.op = op; io.a = a; io.b = b;
        @(negedge clk);
        io.start = 1'b0; io.op = MD_NONE;
        n = 0;
        while (io.busy && n < 100) begin
            check("hold_hi", {32'd0, io.hi}, {32'd0, exp_hi});
            check("hold_lo", {32'd0, io.lo}, {32'd0, exp_lo});
            if (disturb) begin
                io.a     = $urandom;
                io.b     = $urandom;
                io.start = (n == 1);
                io.op    = (n == 1) ? MD_MULT : MD_NONE;
            end
            n++;
            @(negedge clk);
        end
        io.start = 1'b0; io.op = MD_NONE;
        check("busy_cycles", 64'(n), 64'(latency(op)));
        model(op, a, b);
        check("hi", {32'd0, io.hi}, {32'd0, exp_hi});
        check("lo", {32'd0, io.lo}, {32'd0, exp_lo});
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        io.start = 1'b0; io.op = MD_NONE; io.a = '0; io.b = '0;
`ifdef MDU_FLUSH_EN
        io.flush = 1'b0;
`endif
        #12;
        check("rst_busy", {63'd0, io.busy}, 64'd0);
        check("rst_hi", {32'd0, io.hi}, 64'd0);
        check("rst_lo", {32'd0, io.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(MD_MTHI,  32'h0000_1234, 32'd0, 1'b0);
        do_op(MD_DIVU,  32'h0000_0055, 32'd0, 1'b0);
        do_op(MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
        do_op(MD_NONE,  32'hDEAD_BEEF, 32'd1, 1'b0);
        do_op(MD_MTLO,  32'hCAFE_F00D, 32'd0, 1'b0);

        // Async reset in the middle of a divide
        @(negedge clk);
        io.start = 1'b1; io.op = MD_DIV; io.a = 32'd100; io.b = 32'd7;
        @(negedge clk);
        io.start = 1'b0; io.op = MD_NONE;
        @(negedge clk);
        check("pre_rst_busy", {63'd0, io.busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, io.busy}, 64'd0);
        check("async_rst_hi", {32'd0, io.hi}, 64'd0);
        check("async_rst_lo", {32'd0, io.lo}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MDU_FLUSH_EN
        do_op(MD_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
        @(negedge clk);
        io.start = 1'b1; io.op = MD_DIV; io.a = 32'd99; io.b = 32'd4;
        @(negedge clk);
        io.start = 1'b0; io.op = MD_NONE;
        @(negedge clk);
        @(negedge clk);
        check("flush_pre_busy", {63'd0, io.busy}, 64'd1);
        io.flush = 1'b1;
        @(negedge clk);
        io.flush = 1'b0;
        check("flush_busy", {63'd0, io.busy}, 64'd0);
        check("flush_hi", {32'd0, io.hi}, {32'd0, exp_hi});
        check("flush_lo", {32'd0, io.lo}, {32'd0, exp_lo});
        io.start = 1'b1; io.op = MD_MTHI; io.a = 32'h5555_0000; io.flush = 1'b1;
        @(negedge clk);
        io.start = 1'b0; io.op = MD_NONE; io.flush = 1'b0;
        check("flush_start_busy", {63'd0, io.busy}, 64'd0);
        check("flush_start_hi", {32'd0, io.hi}, {32'd0, exp_hi});
`endif

        for (int i = 0; i < 40; i++) begin
            md_op_t      rop;
            logic [31:0] ra, rb;
            rop = md_op_t'($urandom_range(0, 6));
            ra  = pick_val();
            rb  = pick_val();
            do_op(rop, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
